// File: rtl/block_data_memory.sv
// Line-granular backing store below the data cache: one whole-line read or write at a time.
// Latency: acceptance at edge k, access performed at edge k+DELAY, read data valid the cycle after.
// Backpressure: mem_ready low from acceptance until back in IDLE; requests seen outside IDLE are dropped.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   is_input_valid    request present; mem_read / mem_write select the op (exactly one must be set)
//   addr              line address (byte address already shifted); upper bits beyond the array wrap
//   din               line data for writes
//   mem_ready         high only in IDLE
//   is_output_valid   one-cycle pulse in DONE for completed reads
//   dout              registered read line, held until the next read completes
module block_data_memory #(
    parameter int BLOCK_SIZE = 16,
    parameter int MEM_LINES  = 4096,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    mem_ready,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout
);
    localparam int DATA_W = BLOCK_SIZE * 8;
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               mem_we;

    logic [DATA_W-1:0]  mem [MEM_LINES];

    // Address bits above the array index are deliberately discarded (wrap).
    logic               unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IDX_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        din_d   = din_q;
        wr_d    = wr_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // Exactly one of read/write must be set; anything else is dropped.
                if (is_input_valid && (mem_read ^ mem_write)) begin
                    idx_d   = addr[IDX_W-1:0];
                    din_d   = din;
                    wr_d    = mem_write;
                    cnt_d   = CNT_W'(DELAY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = DONE;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        dout_d = mem[idx_q];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
        end
    end

    // Array is never cleared; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[idx_q] <= din_q;
        end
    end

    // Both outputs depend only on registered state, never on inputs.
    assign mem_ready       = (state_q == IDLE);
    assign is_output_valid = (state_q == DONE) && !wr_q;
    assign dout            = dout_q;

endmodule

// File: tb/tb_block_data_memory.sv
module tb_block_data_memory;
    localparam int BLOCK_SIZE = 16;
    localparam int MEM_LINES  = 16;
    localparam int DELAY      = 4;
    localparam int DATA_W     = BLOCK_SIZE * 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              is_input_valid;
    logic [31:0]       addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] din;
    logic              mem_ready;
    logic              is_output_valid;
    logic [DATA_W-1:0] dout;

    block_data_memory #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .MEM_LINES (MEM_LINES),
        .DELAY     (DELAY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_input_valid (is_input_valid),
        .addr           (addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .din            (din),
        .mem_ready      (mem_ready),
        .is_output_valid(is_output_valid),
        .dout           (dout)
    );

    always #5 clk = ~clk;

    // Reference model: the line store as a plain array plus the last read line.
    logic [DATA_W-1:0] ref_mem [MEM_LINES];
    logic [DATA_W-1:0] ref_dout;

    int vectors     = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr           = '0;
        din            = '0;
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One request from IDLE. Valid ops: ready low for DELAY+1 observations,
    // a single valid pulse in the last of them for reads, ready back afterwards.
    // Invalid ops: nothing changes. With hold set, a read of hold_addr is left
    // on the inputs throughout the busy period.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [DATA_W-1:0] d, input logic hold, input logic [31:0] hold_addr);
        int idx;
        logic exp_v;
        idx = int'(a % MEM_LINES);
        check("ready_before_req", {127'd0, mem_ready}, 128'd1);
        is_input_valid = 1'b1;
        mem_read       = rd;
        mem_write      = wr;
        addr           = a;
        din            = d;
        step();
        if (rd != wr) begin
            if (hold) begin
                mem_read  = 1'b1;
                mem_write = 1'b0;
                addr      = hold_addr;
                din       = rand_line();
            end else begin
                idle_inputs();
            end
            for (int i = 0; i <= DELAY; i++) begin
                if (i > 0) step();
                exp_v = rd && (i == DELAY);
                if (exp_v) ref_dout = ref_mem[idx];
                check("ready_busy", {127'd0, mem_ready}, 128'd0);
                check("valid_busy", {127'd0, is_output_valid}, {127'd0, exp_v});
                check("dout_busy", dout, ref_dout);
            end
            if (wr) ref_mem[idx] = d;
            step();
            check("ready_after", {127'd0, mem_ready}, 128'd1);
            check("valid_after", {127'd0, is_output_valid}, 128'd0);
        end else begin
            idle_inputs();
            check("ready_invalid", {127'd0, mem_ready}, 128'd1);
            check("valid_invalid", {127'd0, is_output_valid}, 128'd0);
            check("dout_invalid", dout, ref_dout);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            check("ready_in_reset", {127'd0, mem_ready}, 128'd1);
            check("valid_in_reset", {127'd0, is_output_valid}, 128'd0);
        end
        reset = 1'b0;
        ref_dout = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] line_a;
        logic [DATA_W-1:0] line_w;
        logic [DATA_W-1:0] tmp;
        int op;
        logic [31:0] ra;

        idle_inputs();
        ref_dout = '0;

        // 1. Reset state
        do_reset(2);
        check("reset_dout", dout, 128'd0);

        // Preload every line through the write port.
        line_a = {32{4'hA}};
        for (int i = 0; i < MEM_LINES; i++) begin
            tmp = (i == 3) ? line_a : rand_line();
            req(1'b0, 1'b1, i, tmp, 1'b0, 32'd0);
        end
        check("dout_after_writes", dout, 128'd0);

        // Reset must not disturb the array.
        do_reset(2);
        check("reset_dout_2", dout, 128'd0);

        // 2. Read line 3
        req(1'b1, 1'b0, 32'd3, '0, 1'b0, 32'd0);
        check("line3_dout", dout, line_a);

        // 3. Write line 5 then read it back
        line_w = 128'h0123456789ABCDEF0123456789ABCDEF;
        req(1'b0, 1'b1, 32'd5, line_w, 1'b0, 32'd0);
        req(1'b1, 1'b0, 32'd5, '0, 1'b0, 32'd0);
        check("wr_rd_line5", dout, line_w);

        // 4. Read 7 held valid during a busy read of 5, then accepted
        req(1'b1, 1'b0, 32'd5, '0, 1'b1, 32'd7);
        req(1'b1, 1'b0, 32'd7, '0, 1'b0, 32'd0);

        // 5. Invalid requests: both set, neither set
        req(1'b1, 1'b1, 32'd6, rand_line(), 1'b0, 32'd0);
        req(1'b0, 1'b0, 32'd6, rand_line(), 1'b0, 32'd0);
        for (int i = 0; i < DELAY + 2; i++) begin
            step();
            check("ready_quiet", {127'd0, mem_ready}, 128'd1);
        end
        req(1'b1, 1'b0, 32'd6, '0, 1'b0, 32'd0);

        // 6. Write 0x12 (line 2) aborted by reset two cycles after acceptance
        is_input_valid = 1'b1;
        mem_write      = 1'b1;
        mem_read       = 1'b0;
        addr           = 32'h12;
        din            = rand_line();
        step();
        idle_inputs();
        check("abort_busy", {127'd0, mem_ready}, 128'd0);
        step();
        do_reset(2);
        check("abort_ready", {127'd0, mem_ready}, 128'd1);
        check("abort_dout", dout, 128'd0);
        for (int i = 0; i < DELAY + 2; i++) begin
            step();
            check("abort_no_pulse", {127'd0, is_output_valid}, 128'd0);
        end
        req(1'b1, 1'b0, 32'd2, '0, 1'b0, 32'd0);

        // Randomized mix over the full 32-bit address range
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 4));
            ra = $urandom;
            case (op)
                0, 1: req(1'b1, 1'b0, ra, '0, 1'b0, 32'd0);
                2:    req(1'b0, 1'b1, ra, rand_line(), 1'b0, 32'd0);
                3:    req(1'b1, 1'b1, ra, rand_line(), 1'b0, 32'd0);
                default: req(1'b0, 1'b0, ra, rand_line(), 1'b0, 32'd0);
            endcase
        end

        // Final sweep: every line matches the model
        for (int i = 0; i < MEM_LINES; i++) begin
            req(1'b1, 1'b0, i + 32'h100, '0, 1'b0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
